// File: rtl/bp_resolve_queue.sv
// bp_resolve_queue: in-order FIFO of in-flight branch predictions; drives PHT training and mispredict redirect
module bp_resolve_queue #(
   parameter int DEPTH = 4,
   parameter int IDX_W = 10,
   parameter int PC_W = 32,
   localparam int CW = $clog2(DEPTH + 1),
   localparam int PW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_valid,
   input  logic [IDX_W-1:0] push_index,
   input  logic             push_taken,
   input  logic [PC_W-1:0]  push_pc,
   output logic             push_ready,
   input  logic             res_valid,
   input  logic             res_taken,
   input  logic [PC_W-1:0]  res_target,
   input  logic             pipe_flush,
   output logic             presuccess,
   output logic             prefail,
   output logic [IDX_W-1:0] fix_index,
   output logic             redirect_valid,
   output logic [PC_W-1:0]  redirect_pc,
   output logic [CW-1:0]    count,
   output logic             err_underflow
);
   logic [IDX_W-1:0] idx_q [DEPTH];
   logic [PC_W-1:0]  pc_q [DEPTH];
   logic [DEPTH-1:0] tkn_q;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             ps_q, ps_d, pf_q, pf_d, rdv_q, rdv_d, err_q, err_d;
   logic [IDX_W-1:0] fix_q, fix_d;
   logic [PC_W-1:0]  rpc_q, rpc_d;
   logic             empty, res_go, mis, kill, push_go, pop;

   // a mispredict kills everything younger than the head, including a same-cycle push
   always_comb begin
      empty      = count_q == '0;
      push_ready = count_q != CW'(DEPTH);
      res_go     = res_valid & ~empty & ~pipe_flush;
      mis        = res_go & (res_taken != tkn_q[rd_ptr_q]);
      kill       = pipe_flush | mis;
      push_go    = push_valid & push_ready & ~kill;
      pop        = res_go & ~mis;
      count_d    = kill ? '0 : count_q + CW'(push_go) - CW'(pop);
      rd_ptr_d   = kill ? wr_ptr_q : rd_ptr_q + PW'(pop);
      wr_ptr_d   = wr_ptr_q + PW'(push_go);
      ps_d       = res_go & res_taken;
      pf_d       = res_go & ~res_taken;
      fix_d      = res_go ? idx_q[rd_ptr_q] : '0;
      rdv_d      = mis;
      rpc_d      = ~mis ? '0 : res_taken ? res_target : pc_q[rd_ptr_q] + PC_W'(4);
      err_d      = res_valid & empty & ~pipe_flush;
   end

   always_ff @(posedge clk) begin
      if (push_go) begin
         idx_q[wr_ptr_q] <= push_index;
         pc_q[wr_ptr_q]  <= push_pc;
         tkn_q[wr_ptr_q] <= push_taken;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         ps_q     <= 1'b0;
         pf_q     <= 1'b0;
         fix_q    <= '0;
         rdv_q    <= 1'b0;
         rpc_q    <= '0;
         err_q    <= 1'b0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         ps_q     <= ps_d;
         pf_q     <= pf_d;
         fix_q    <= fix_d;
         rdv_q    <= rdv_d;
         rpc_q    <= rpc_d;
         err_q    <= err_d;
      end
   end

   assign presuccess     = ps_q;
   assign prefail        = pf_q;
   assign fix_index      = fix_q;
   assign redirect_valid = rdv_q;
   assign redirect_pc    = rpc_q;
   assign count          = count_q;
   assign err_underflow  = err_q;
endmodule

// File: tb/tb_bp_resolve_queue.sv
// tb_bp_resolve_queue: vector table, hand sequences and a queue-based reference model for bp_resolve_queue
module tb_bp_resolve_queue;
   localparam int DEPTH = 4;

   typedef struct {
      logic        pv; logic [9:0] pi; logic pt; logic [31:0] pp;
      logic        rv; logic rt; logic [31:0] rtgt; logic fl;
      logic        e_ps, e_pf; logic [9:0] e_fix; logic e_rd; logic [31:0] e_rpc;
      int          e_cnt; logic e_err;
   } vec_t;

   typedef struct {
      logic [9:0]  idx; logic tk; logic [31:0] pc;
   } ent_t;

   logic        clk = 0, rst_n = 0;
   logic        push_valid = 0, push_taken = 0, res_valid = 0, res_taken = 0, pipe_flush = 0;
   logic [9:0]  push_index = 0;
   logic [31:0] push_pc = 0, res_target = 0;
   logic        push_ready, presuccess, prefail, redirect_valid, err_underflow;
   logic [9:0]  fix_index;
   logic [31:0] redirect_pc;
   logic [2:0]  count;

   int checks = 0, passes = 0;
   ent_t q[$];
   vec_t tbl[$];

   bp_resolve_queue #(.DEPTH(DEPTH), .IDX_W(10), .PC_W(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .push_valid(push_valid), .push_index(push_index), .push_taken(push_taken), .push_pc(push_pc),
      .push_ready(push_ready),
      .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target), .pipe_flush(pipe_flush),
      .presuccess(presuccess), .prefail(prefail), .fix_index(fix_index),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .count(count), .err_underflow(err_underflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a === e) passes++;
      else $display("FAIL %s: got %0h want %0h", n, a, e);
   endtask

   function automatic vec_t mk(input logic pv, input logic [9:0] pi, input logic pt, input logic [31:0] pp,
                               input logic rv, input logic rt, input logic [31:0] rtgt, input logic fl,
                               input logic e_ps, input logic e_pf, input logic [9:0] e_fix, input logic e_rd,
                               input logic [31:0] e_rpc, input int e_cnt, input logic e_err);
      vec_t v;
      v.pv = pv; v.pi = pi; v.pt = pt; v.pp = pp; v.rv = rv; v.rt = rt; v.rtgt = rtgt; v.fl = fl;
      v.e_ps = e_ps; v.e_pf = e_pf; v.e_fix = e_fix; v.e_rd = e_rd; v.e_rpc = e_rpc;
      v.e_cnt = e_cnt; v.e_err = e_err;
      return v;
   endfunction

   task automatic check_outs(input string n, input vec_t v);
      chk({n, ".presuccess"}, 32'(presuccess), 32'(v.e_ps));
      chk({n, ".prefail"}, 32'(prefail), 32'(v.e_pf));
      chk({n, ".fix_index"}, 32'(fix_index), 32'(v.e_fix));
      chk({n, ".redirect_valid"}, 32'(redirect_valid), 32'(v.e_rd));
      chk({n, ".redirect_pc"}, redirect_pc, v.e_rpc);
      chk({n, ".count"}, 32'(count), 32'(v.e_cnt));
      chk({n, ".err_underflow"}, 32'(err_underflow), 32'(v.e_err));
      chk({n, ".push_ready"}, 32'(push_ready), 32'(v.e_cnt < DEPTH));
   endtask

   task automatic step(input string n, input vec_t v);
      push_valid = v.pv; push_index = v.pi; push_taken = v.pt; push_pc = v.pp;
      res_valid = v.rv; res_taken = v.rt; res_target = v.rtgt; pipe_flush = v.fl;
      @(posedge clk);
      #1;
      check_outs(n, v);
   endtask

   // reference: flush wins, then resolution against the oldest entry, then the push
   task automatic model(inout vec_t v);
      int   sz = q.size();
      ent_t h, e;
      e.idx = v.pi; e.tk = v.pt; e.pc = v.pp;
      v.e_ps = 0; v.e_pf = 0; v.e_fix = 0; v.e_rd = 0; v.e_rpc = 0; v.e_err = 0;
      if (v.fl) q.delete();
      else if (v.rv && sz == 0) begin
         v.e_err = 1;
         if (v.pv) q.push_back(e);
      end else if (v.rv) begin
         h = q[0];
         v.e_ps = v.rt; v.e_pf = !v.rt; v.e_fix = h.idx;
         if (v.rt == h.tk) begin
            void'(q.pop_front());
            if (v.pv && sz < DEPTH) q.push_back(e);
         end else begin
            v.e_rd = 1;
            v.e_rpc = v.rt ? v.rtgt : h.pc + 32'd4;
            q.delete();
         end
      end else if (v.pv && sz < DEPTH) q.push_back(e);
      v.e_cnt = q.size();
   endtask

   task automatic do_reset();
      rst_n = 0;
      push_valid = 0; res_valid = 0; pipe_flush = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1;
      q.delete();
   endtask

   initial begin
      vec_t v;
      do_reset();
      check_outs("reset", mk(0,0,0,0, 0,0,0,0, 0,0,0,0,0,0,0));

      tbl.push_back(mk(1,'h005,1,'h100, 0,0,0,0,       0,0,0,0,0,1,0));
      tbl.push_back(mk(0,0,0,0,         1,1,0,0,       1,0,'h005,0,0,0,0));
      tbl.push_back(mk(0,0,0,0,         0,0,0,0,       0,0,0,0,0,0,0));
      tbl.push_back(mk(1,'h3FF,1,'h200, 0,0,0,0,       0,0,0,0,0,1,0));
      tbl.push_back(mk(0,0,0,0,         1,0,0,0,       0,1,'h3FF,1,'h204,0,0));
      tbl.push_back(mk(1,'h011,0,'h300, 0,0,0,0,       0,0,0,0,0,1,0));
      tbl.push_back(mk(1,'h012,0,'h304, 0,0,0,0,       0,0,0,0,0,2,0));
      tbl.push_back(mk(1,'h013,0,'h308, 0,0,0,0,       0,0,0,0,0,3,0));
      tbl.push_back(mk(1,'h014,0,'h30C, 1,1,'h800,0,   1,0,'h011,1,'h800,0,0));
      tbl.push_back(mk(0,0,0,0,         1,1,0,0,       0,0,0,0,0,0,1));
      tbl.push_back(mk(0,0,0,0,         0,0,0,0,       0,0,0,0,0,0,0));
      tbl.push_back(mk(1,'h020,1,'hFFFFFFFC, 0,0,0,0,  0,0,0,0,0,1,0));
      tbl.push_back(mk(0,0,0,0,         1,0,0,0,       0,1,'h020,1,0,0,0));
      foreach (tbl[i]) step($sformatf("tbl%0d", i), tbl[i]);

      // fill, overflow, full push+pop, drain and wrap
      for (int i = 0; i < 4; i++) step($sformatf("fill%0d", i), mk(1,10'('h40+i),1,32'('h400+4*i), 0,0,0,0, 0,0,0,0,0,i+1,0));
      step("overflow", mk(1,'h44,1,'h410, 0,0,0,0, 0,0,0,0,0,4,0));
      step("fullpop", mk(1,'h45,1,'h450, 1,1,0,0, 1,0,'h040,0,0,3,0));
      for (int i = 1; i < 4; i++) step($sformatf("drain%0d", i), mk(0,0,0,0, 1,1,0,0, 1,0,10'('h40+i),0,0,3-i,0));
      step("wrap_p0", mk(1,'h50,0,'h500, 0,0,0,0, 0,0,0,0,0,1,0));
      step("wrap_p1", mk(1,'h51,0,'h504, 0,0,0,0, 0,0,0,0,0,2,0));
      step("wrap_r0", mk(0,0,0,0, 1,0,0,0, 0,1,'h050,0,0,1,0));
      step("wrap_r1", mk(0,0,0,0, 1,0,0,0, 0,1,'h051,0,0,0,0));

      // flush beats same-cycle resolve and push
      step("fl_p0", mk(1,'h60,1,'h600, 0,0,0,0, 0,0,0,0,0,1,0));
      step("fl_p1", mk(1,'h61,1,'h604, 0,0,0,0, 0,0,0,0,0,2,0));
      step("flush", mk(1,'h62,1,'h620, 1,1,0,1, 0,0,0,0,0,0,0));
      step("postfl", mk(0,0,0,0, 0,0,0,0, 0,0,0,0,0,0,0));

      // asynchronous reset between clock edges
      step("ar_p0", mk(1,'h71,1,'h700, 0,0,0,0, 0,0,0,0,0,1,0));
      step("ar_p1", mk(1,'h72,1,'h704, 0,0,0,0, 0,0,0,0,0,2,0));
      step("ar_r", mk(1,'h73,1,'h708, 1,1,0,0, 1,0,'h071,0,0,2,0));
      #2 rst_n = 0;
      #1 check_outs("async_rst", mk(0,0,0,0, 0,0,0,0, 0,0,0,0,0,0,0));
      do_reset();

      for (int i = 0; i < 400; i++) begin
         v.pv = $urandom_range(0, 9) < 7; v.pi = 10'($urandom); v.pt = 1'($urandom); v.pp = $urandom;
         v.rv = $urandom_range(0, 9) < 4; v.rtgt = $urandom; v.fl = $urandom_range(0, 19) == 0;
         v.rt = (q.size() > 0 && $urandom_range(0, 3) != 0) ? q[0].tk : 1'($urandom);
         model(v);
         step($sformatf("rnd%0d", i), v);
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
